// File: rtl/resolution_downscaler_stream.sv
// Streaming 3:2 RGB888 downscaler: every 3x3 input tile becomes a 2x2 output tile.
// Build option DOWNSCALE_DECIMATE_EN replaces quadrant averaging with plain decimation.
module resolution_downscaler_stream #(
   parameter int IMG_W = 1920,
   parameter int IMG_H = 1080
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [2:0][7:0] s_data,
   input  logic            s_valid,
   input  logic            s_sof,
   output logic            s_ready,
   output logic [2:0][7:0] m_data,
   output logic            m_valid,
   output logic            m_sof,
   output logic            m_eol,
   input  logic            m_ready
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0] col_q, col_cur, col_nxt;
   logic [RW-1:0] row_q, row_cur, row_nxt;
   logic [1:0]    cp_q, cp_cur, cp_nxt;
   logic [1:0]    rp_q, rp_cur, rp_nxt;
   logic          accept;
   logic          emit;
   logic [2:0][7:0] pix;

   assign s_ready = !m_valid || m_ready;
   assign accept  = s_valid && s_ready;

   // A start-of-frame beat is treated as (0,0) regardless of the tracked position.
   always_comb begin
      col_cur = s_sof ? '0 : col_q;
      row_cur = s_sof ? '0 : row_q;
      cp_cur  = s_sof ? '0 : cp_q;
      rp_cur  = s_sof ? '0 : rp_q;
   end

   always_comb begin
      col_nxt = col_cur + 1'b1;
      cp_nxt  = (cp_cur == 2'd2) ? 2'd0 : cp_cur + 2'd1;
      row_nxt = row_cur;
      rp_nxt  = rp_cur;
      if (col_cur == COL_LAST) begin
         col_nxt = '0;
         cp_nxt  = 2'd0;
         if (row_cur == ROW_LAST) begin
            row_nxt = '0;
            rp_nxt  = 2'd0;
         end else begin
            row_nxt = row_cur + 1'b1;
            rp_nxt  = (rp_cur == 2'd2) ? 2'd0 : rp_cur + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_q <= '0;
         row_q <= '0;
         cp_q  <= 2'd0;
         rp_q  <= 2'd0;
      end else if (accept) begin
         col_q <= col_nxt;
         row_q <= row_nxt;
         cp_q  <= cp_nxt;
         rp_q  <= rp_nxt;
      end
   end

   assign emit = accept && (rp_cur != 2'd0) && (cp_cur != 2'd0);

`ifdef DOWNSCALE_DECIMATE_EN
   assign pix = s_data;
`else
   logic [2:0][7:0] lbuf [IMG_W];
   logic [2:0][7:0] top_px;
   logic [2:0][7:0] l_q;
   logic [2:0][7:0] tl_q;

   function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[8:1];
   endfunction

   // Read-before-write: top_px is still the previous row's pixel in this column.
   assign top_px = lbuf[col_cur];

   always_ff @(posedge clk) begin
      if (accept) begin
         lbuf[col_cur] <= s_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         l_q  <= '0;
         tl_q <= '0;
      end else if (accept) begin
         l_q  <= s_data;
         tl_q <= top_px;
      end
   end

   always_comb begin
      pix = '0;
      for (int i = 0; i < 3; i++) begin
         pix[i] = avg2(avg2(tl_q[i], top_px[i]), avg2(l_q[i], s_data[i]));
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_sof   <= 1'b0;
         m_eol   <= 1'b0;
      end else if (emit) begin
         m_valid <= 1'b1;
         m_data  <= pix;
         m_sof   <= (row_cur == RW'(1)) && (col_cur == CW'(1));
         m_eol   <= (col_cur == COL_LAST);
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: doc/resolution_downscaler_stream.md
Name: resolution_downscaler_stream

Overview:
- Streaming 3:2 resolution downscaler for RGB888 raster video, one pixel per beat on a valid/ready stream.
- Inverse of the 2x2->3x3 upscaler cell. Each non-overlapping 3x3 input tile yields a 2x2 output tile.
- Each output pixel is the rounded average of one of the tile's four overlapping 2x2 quadrants, using the same pairwise-floor averaging as the upscaler centre.
- Sits between the frame source and the HDMI output path, for downscale and round-trip verification.

Parameters:
- IMG_W, 1920, input active width in pixels; multiple of 3.
- IMG_H, 1080, input active height in lines; multiple of 3.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- s_data  in  [2:0][7:0]  input pixel {R,G,B}; channels processed independently
- s_valid  in  1  input beat valid
- s_sof  in  1  start-of-frame; qualifies the first pixel of a frame
- s_ready  out  1  input can be accepted
- m_data  out  [2:0][7:0]  output pixel
- m_valid  out  1  output beat valid
- m_sof  out  1  first output pixel of a frame
- m_eol  out  1  last output pixel of an output line
- m_ready  in  1  downstream accepts

Behaviour:
- Reset (rst_n low at a clk edge):
  - m_valid=0, m_data=0, m_sof=0, m_eol=0.
  - Column, row and both mod-3 phase counters = 0.
  - Line buffer is not cleared: every entry is rewritten on row phase 0 before it is read.
  - Reset mid-frame abandons the frame; the next accepted pixel is treated as (0,0) whatever s_sof is.
- Handshake:
  - s_ready = !m_valid || m_ready (combinational).
  - A beat is accepted when s_valid && s_ready.
  - Output register holds m_data and flags stable while m_valid && !m_ready.
  - m_valid drops after a handshake if no new output was produced in that cycle.
- Position tracking:
  - col counts 0..IMG_W-1 and row counts 0..IMG_H-1 on accepted beats; cp=col%3 and rp=row%3 kept as separate phase counters.
  - col wraps to 0 and row increments; at (IMG_W-1, IMG_H-1) both wrap to 0.
  - An accepted beat with s_sof=1 forces that pixel to position (0,0), realigning mid-frame.
- Storage:
  - Line buffer: IMG_W x 24 bits, addressed by col. Read-before-write, so the read returns the previous row's pixel in the same column.
  - Registers hold the previous column's current-row pixel (L) and its line-buffer pixel (TL).
- Emission:
  - An output is produced on an accepted beat when rp in {1,2} and cp in {1,2}.
  - Quadrant: TL, T (line buffer read), L, C (current pixel).
  - avg2(a,b) = (a+b)>>1 with a 9-bit intermediate; out = avg2(avg2(TL,T), avg2(L,C)), per channel, floor at every step.
  - Latency: m_valid rises the cycle after the accepting edge.
- Output flags:
  - m_sof=1 on the output produced at row 1, col 1 of the frame.
  - m_eol=1 on the output produced at col IMG_W-1.
- Throughput: output size is (2*IMG_W/3) x (2*IMG_H/3). The input stalls only through s_ready backpressure, since at most one output is produced per input beat.

Optional Feature:
- Macro: DOWNSCALE_DECIMATE_EN.
- Defined:
  - Output pixel = C (bottom-right pixel of the quadrant), no averaging.
  - Emission positions, flags, latency and handshake are unchanged.
  - Line buffer and TL/L registers are not instantiated.
- Undefined: quadrant averaging as specified above.

Test Plan:
- IMG_W=6, IMG_H=6; all pixels {10,10,10}; m_ready=1 -> exactly 16 outputs, all {10,10,10}.
  - m_sof on output 0 only; m_eol on outputs 3, 7, 11, 15.
- R/G channels of tile rows [10,5,0], [10,7,5], [10,10,10]; B=10 everywhere -> R/G outputs 7, 4, 9, 8 in raster order; B stays 10.
- Same stream with m_ready toggling 1,0,0,1:
  - s_ready low exactly while m_valid && !m_ready.
  - m_data held stable during stalls.
  - No output lost or duplicated.
- rst_n low for 1 cycle in the middle of row 4 -> m_valid=0 next cycle; the following full frame produces the correct 16 outputs with m_sof on the first.
- s_sof asserted on input beat 20 of a frame -> counters realign; the first output after it appears at the 8th beat from beat 20 with m_sof=1.
- DOWNSCALE_DECIMATE_EN defined, same R/G tile -> outputs 7, 5, 10, 10.
